// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
//
// Purpose: FSM state encoding, datapath widths and fetch constants used by
//          instr_fetch_unit and fetch_out_reg.
// Contents: fetch_state_e (BOOT, RUN, FAULT), INSTR_W, PC_INCR, NOP.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    localparam int          INSTR_W = 32;
    localparam logic [31:0] PC_INCR = 32'd4;
    // Canonical ADDI x0,x0,0; reserved for bubble insertion downstream.
    localparam logic [31:0] NOP     = 32'h0000_0013;

endpackage

// File: rtl/fetch_out_reg.sv
// rtl/fetch_out_reg.sv - valid/ready output register between fetch and decode
//
// Purpose: holds one fetched instruction with its pc and pc+4 until decode
//          accepts it; flush drops the held entry and blocks capture.
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   load_i                capture instr_i/pc_i/pc_plus4_i this cycle
//   flush_i               invalidate the held entry (wins over load_i)
//   ready_i               downstream accepts the held entry this cycle
//   instr_i, pc_i, pc_plus4_i  entry to capture
//   valid_o, instr_o, pc_o, pc_plus4_o  held entry
module fetch_out_reg
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               flush_i,
    input  logic               ready_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [31:0]        pc_i,
    input  logic [31:0]        pc_plus4_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [31:0]        pc_o,
    output logic [31:0]        pc_plus4_o
);

    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [31:0]        pc_q;
    logic [31:0]        pc_plus4_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            instr_q    <= '0;
            pc_q       <= '0;
            pc_plus4_q <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q    <= 1'b1;
            instr_q    <= instr_i;
            pc_q       <= pc_i;
            pc_plus4_q <= pc_plus4_i;
        end else if (ready_i) begin
            // Entry consumed with nothing new behind it.
            valid_q <= 1'b0;
        end
    end

    assign valid_o    = valid_q;
    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - program counter and fetch stage feeding decode
//
// Purpose: holds the PC, addresses the combinational instruction memory,
//          registers fetched words toward decode with valid/ready, applies
//          redirects and flags out-of-range or misaligned PCs.
// Ports:
//   clk, reset           rising-edge clock, async active-high reset
//   imem_addr            word address {2'b00, pc[31:2]}
//   imem_data            combinational read data for imem_addr
//   redirect_valid/_pc   branch/jump target load, flushes output
//   id_ready             decode accepts id_* this cycle
//   id_valid, id_instr, id_pc, id_pc_plus4   fetched instruction to decode
//   fault                sticky bad-PC indication
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          IMEM_DEPTH = 64
) (
    input  logic               clk,
    input  logic               reset,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               id_ready,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_pc_plus4,
    output logic               fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         fault_q, fault_d;
    logic         load, flush;
    logic [31:0]  pc_plus4;

    function automatic logic pc_ok(input logic [31:0] p);
        return (p[1:0] == 2'b00) && ({2'b00, p[31:2]} < 32'(IMEM_DEPTH));
    endfunction

    assign pc_plus4 = pc_q + PC_INCR;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        load    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            BOOT: begin
                // Memory is initialising this cycle, so nothing is fetched.
                state_d = RUN;
                if (redirect_valid) begin
                    pc_d  = redirect_pc;
                    flush = 1'b1;
                end
            end
            RUN: begin
                if (redirect_valid) begin
                    pc_d  = redirect_pc;
                    flush = 1'b1;
                end else if (!pc_ok(pc_q)) begin
                    // Output register keeps draining via id_ready.
                    state_d = FAULT;
                    fault_d = 1'b1;
                end else if (!id_valid || id_ready) begin
                    load = 1'b1;
                    pc_d = pc_plus4;
                end
            end
            FAULT: begin
                if (redirect_valid) begin
                    pc_d  = redirect_pc;
                    flush = 1'b1;
                    if (pc_ok(redirect_pc)) begin
                        state_d = RUN;
                        fault_d = 1'b0;
                    end
                end
            end
            default: state_d = BOOT;
        endcase
    end

    fetch_out_reg u_out (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load),
        .flush_i    (flush),
        .ready_i    (id_ready),
        .instr_i    (imem_data),
        .pc_i       (pc_q),
        .pc_plus4_i (pc_plus4),
        .valid_o    (id_valid),
        .instr_o    (id_instr),
        .pc_o       (id_pc),
        .pc_plus4_o (id_pc_plus4)
    );

    assign imem_addr = {2'b00, pc_q[31:2]};
    assign fault     = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        fault;

    logic [31:0] mem [0:63];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign imem_data = (imem_addr < 32'd64) ? mem[imem_addr[5:0]] : 32'h0;

    instr_fetch_unit #(.RESET_PC(32'h0), .IMEM_DEPTH(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .fault          (fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0]  = 32'h3;
        mem[1]  = 32'h8;
        mem[8]  = 32'ha;
        mem[15] = 32'hc;

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;
        #12;
        check("rst_valid", {31'b0, id_valid}, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_instr", id_instr, 32'h0);
        check("rst_pc4", id_pc_plus4, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // BOOT cycle, then streaming fetch
        step();
        check("boot_valid", {31'b0, id_valid}, 32'h0);
        step();
        check("f0_valid", {31'b0, id_valid}, 32'h1);
        check("f0_instr", id_instr, 32'h3);
        check("f0_pc", id_pc, 32'h0);
        check("f0_addr", imem_addr, 32'h1);

        // stall three cycles
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", {31'b0, id_valid}, 32'h1);
            check("stall_instr", id_instr, 32'h3);
            check("stall_pc", id_pc, 32'h0);
            check("stall_addr", imem_addr, 32'h1);
        end
        id_ready = 1'b1;
        step();
        check("f1_instr", id_instr, 32'h8);
        check("f1_pc", id_pc, 32'h4);
        check("f1_pc4", id_pc_plus4, 32'h8);
        step();
        check("f2_instr", id_instr, 32'h0);
        check("f2_pc", id_pc, 32'h8);

        // redirect with id_ready=1 in the same cycle
        redirect(32'h20);
        check("rd_flush", {31'b0, id_valid}, 32'h0);
        check("rd_addr", imem_addr, 32'h8);
        step();
        check("rd_valid", {31'b0, id_valid}, 32'h1);
        check("rd_instr", id_instr, 32'ha);
        check("rd_pc", id_pc, 32'h20);
        check("rd_pc4", id_pc_plus4, 32'h24);

        // run off the end of memory
        redirect(32'hF0);
        for (int i = 0; i < 4; i++) step();
        check("end_pc", id_pc, 32'hFC);
        check("end_valid", {31'b0, id_valid}, 32'h1);
        check("end_addr", imem_addr, 32'h40);
        step();
        check("oor_fault", {31'b0, fault}, 32'h1);
        check("oor_valid", {31'b0, id_valid}, 32'h0);
        step();
        check("oor_sticky", {31'b0, fault}, 32'h1);
        check("oor_nocap", {31'b0, id_valid}, 32'h0);
        redirect(32'h3C);
        check("rec_fault", {31'b0, fault}, 32'h0);
        check("rec_valid", {31'b0, id_valid}, 32'h0);
        step();
        check("rec_instr", id_instr, 32'hc);
        check("rec_pc", id_pc, 32'h3C);

        // misaligned target
        redirect(32'h6);
        step();
        check("mis_fault", {31'b0, fault}, 32'h1);
        check("mis_valid", {31'b0, id_valid}, 32'h0);
        redirect(32'h0);
        check("mis_rec", {31'b0, fault}, 32'h0);
        step();
        check("mis_instr", id_instr, 32'h3);
        check("mis_pc", id_pc, 32'h0);

        // async reset while stalled with valid output
        id_ready = 1'b0;
        step();
        check("pre_rst_valid", {31'b0, id_valid}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", {31'b0, id_valid}, 32'h0);
        check("arst_fault", {31'b0, fault}, 32'h0);
        check("arst_addr", imem_addr, 32'h0);
        check("arst_instr", id_instr, 32'h0);
        check("arst_pc", id_pc, 32'h0);
        @(negedge clk);
        reset    = 1'b0;
        id_ready = 1'b1;
        step();
        check("boot2_valid", {31'b0, id_valid}, 32'h0);
        step();
        check("boot2_instr", id_instr, 32'h3);
        check("boot2_pc", id_pc, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
